// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: states, opcodes,
// ALU_op classes, mux select codes and the packed control word.
package multicycle_main_control_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_EXEC_I   = 4'd10;
  localparam logic [3:0] S_WB_I     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FIELD = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_inst_sel;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI: is_known_op = 1'b1;
      default: is_known_op = 1'b0;
    endcase
  endfunction

  // Unknown opcodes fall back to FETCH whether or not they are trapped.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:                 decode_target = S_EXEC_R;
      OP_LW, OP_SW:             decode_target = S_MEM_ADDR;
      OP_BEQ:                   decode_target = S_BRANCH;
      OP_J:                     decode_target = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI: decode_target = S_EXEC_I;
      default:                  decode_target = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main control FSM (master) and the datapath /
// ALU decoder (slave).
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       alu_inst_sel;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           alu_inst_sel, pc_source, illegal_op, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           alu_inst_sel, pc_source, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_main_control_rom.sv
// control_output_rom: purely combinational map from current state (plus the
// live/latched opcode and effective mem_ready) to the control word.
module control_output_rom
  import multicycle_main_control_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic [3:0] state_i,
  input  logic [5:0] op_live_i,
  input  logic [5:0] op_lat_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Moore decode; only the FETCH IR/PC loads and DECODE trap look at inputs.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
        if (TRAP_ILLEGAL && !is_known_op(op_live_i)) begin
          ctrl_o.illegal_op = 1'b1;
        end else begin
          ctrl_o.illegal_op = 1'b0;
        end
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a    = 1'b1;
        ctrl_o.alu_src_b    = SRCB_B;
        ctrl_o.alu_op       = ALUOP_FIELD;
        ctrl_o.alu_inst_sel = 1'b0;
      end
      S_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        // andi/ori let the ALU decoder see the opcode; addi is a plain add.
        if ((op_lat_i == OP_ANDI) || (op_lat_i == OP_ORI)) begin
          ctrl_o.alu_op       = ALUOP_FIELD;
          ctrl_o.alu_inst_sel = 1'b1;
        end else begin
          ctrl_o.alu_op       = ALUOP_ADD;
          ctrl_o.alu_inst_sel = 1'b0;
        end
      end
      S_WB_I: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath: state/opcode registers,
// next-state logic and reset gating of the control word.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  multicycle_main_control_if.master     bus
);

  logic [3:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       rdy_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;

  assign rdy_s = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  control_output_rom #(
    .TRAP_ILLEGAL (TRAP_ILLEGAL)
  ) u_rom (
    .state_i     (state_q),
    .op_live_i   (bus.opcode),
    .op_lat_i    (op_q),
    .mem_ready_i (rdy_s),
    .ctrl_o      (ctrl_s)
  );

  // Next state; mem_ready only matters in the three memory-access states.
  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    case (state_q)
      S_FETCH:    state_d = rdy_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = decode_target(bus.opcode);
        op_d    = bus.opcode;
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = rdy_s ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = rdy_s ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State and latched-opcode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // rst kills every strobe combinationally so nothing half-completes.
  always_comb begin
    if (rst) begin
      ctrl_out_s = '0;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign bus.pc_write      = ctrl_out_s.pc_write;
  assign bus.pc_write_cond = ctrl_out_s.pc_write_cond;
  assign bus.i_or_d        = ctrl_out_s.i_or_d;
  assign bus.mem_read      = ctrl_out_s.mem_read;
  assign bus.mem_write     = ctrl_out_s.mem_write;
  assign bus.ir_write      = ctrl_out_s.ir_write;
  assign bus.reg_dst       = ctrl_out_s.reg_dst;
  assign bus.reg_write     = ctrl_out_s.reg_write;
  assign bus.mem_to_reg    = ctrl_out_s.mem_to_reg;
  assign bus.alu_src_a     = ctrl_out_s.alu_src_a;
  assign bus.alu_src_b     = ctrl_out_s.alu_src_b;
  assign bus.alu_op        = ctrl_out_s.alu_op;
  assign bus.alu_inst_sel  = ctrl_out_s.alu_inst_sel;
  assign bus.pc_source     = ctrl_out_s.pc_source;
  assign bus.illegal_op    = ctrl_out_s.illegal_op;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed instruction table, hand-written
// reset / wait-state sequences, and random instruction streams vs. a model.
module tb_multicycle_main_control;
  import multicycle_main_control_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, irw, rdst, rw, m2r, sa;
    logic [1:0] sb, aop;
    logic       sel;
    logic [1:0] psrc;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op;
    exp_t       exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         lat;
    int         idx;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  step_t q[$];

  multicycle_main_control_if bus();

  multicycle_main_control #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t a;
    a.st = bus.state_o;     a.pcw = bus.pc_write;  a.pcwc = bus.pc_write_cond;
    a.iord = bus.i_or_d;    a.mr = bus.mem_read;   a.mw = bus.mem_write;
    a.irw = bus.ir_write;   a.rdst = bus.reg_dst;  a.rw = bus.reg_write;
    a.m2r = bus.mem_to_reg; a.sa = bus.alu_src_a;  a.sb = bus.alu_src_b;
    a.aop = bus.alu_op;     a.sel = bus.alu_inst_sel;
    a.psrc = bus.pc_source; a.ill = bus.illegal_op;
    return a;
  endfunction

  function automatic exp_t e0(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic bit known(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
           op == 6'b000010 || op == 6'b001000 || op == 6'b001100 || op == 6'b001101;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic [5:0] op, output exp_t a);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    #1;
    a = sample();
  endtask

  task automatic push(input logic rdy, input logic [5:0] op, input exp_t e);
    step_t s;
    s.rdy = rdy;
    s.op  = op;
    s.exp = e;
    q.push_back(s);
  endtask

  // Reference: per-cycle expected control words for one instruction, read
  // straight off the instruction-class sequencing rules.
  task automatic model_instr(input logic [5:0] op, input int wf, input int wm);
    exp_t e;
    for (int i = 0; i < wf; i++) begin
      e = e0(S_FETCH); e.mr = 1'b1; e.sb = 2'b01;
      push(1'b0, 6'($urandom), e);
    end
    e = e0(S_FETCH); e.mr = 1'b1; e.sb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
    push(1'b1, 6'($urandom), e);
    e = e0(S_DECODE); e.sb = 2'b11; e.ill = !known(op);
    push(1'($urandom), op, e);
    case (op)
      6'b000000: begin
        e = e0(S_EXEC_R); e.sa = 1'b1; e.aop = 2'b10;
        push(1'($urandom), 6'($urandom), e);
        e = e0(S_WB_R); e.rw = 1'b1; e.rdst = 1'b1;
        push(1'($urandom), 6'($urandom), e);
      end
      6'b100011, 6'b101011: begin
        e = e0(S_MEM_ADDR); e.sa = 1'b1; e.sb = 2'b10;
        push(1'($urandom), 6'($urandom), e);
        e = e0(op == 6'b100011 ? S_MEM_RD : S_MEM_WR); e.iord = 1'b1;
        if (op == 6'b100011) e.mr = 1'b1; else e.mw = 1'b1;
        for (int i = 0; i < wm; i++) push(1'b0, 6'($urandom), e);
        push(1'b1, 6'($urandom), e);
        if (op == 6'b100011) begin
          e = e0(S_MEM_WB); e.rw = 1'b1; e.m2r = 1'b1;
          push(1'($urandom), 6'($urandom), e);
        end
      end
      6'b000100: begin
        e = e0(S_BRANCH); e.sa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.psrc = 2'b01;
        push(1'($urandom), 6'($urandom), e);
      end
      6'b000010: begin
        e = e0(S_JUMP); e.pcw = 1'b1; e.psrc = 2'b10;
        push(1'($urandom), 6'($urandom), e);
      end
      6'b001000, 6'b001100, 6'b001101: begin
        e = e0(S_EXEC_I); e.sa = 1'b1; e.sb = 2'b10;
        if (op != 6'b001000) begin e.aop = 2'b10; e.sel = 1'b1; end
        push(1'($urandom), 6'($urandom), e);
        e = e0(S_WB_I); e.rw = 1'b1;
        push(1'($urandom), 6'($urandom), e);
      end
      default: ;
    endcase
  endtask

  // Runs one instruction (opcode presented only in its DECODE cycle) and
  // measures length; state_o steers the stimulus only.
  task automatic exec_instr(input logic [5:0] op, input int wait_rd, input int idx,
                            output int cycles, output exp_t at_idx,
                            output int mr_rd, output int m2r);
    int   waited;
    bit   done;
    exp_t a;
    waited = 0; done = 1'b0; cycles = 0; mr_rd = 0; m2r = 0; at_idx = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (k > 0 && bus.state_o == S_FETCH) begin
        done = 1'b1;
        cycles = k;
        bus.mem_ready = 1'b0;
      end else begin
        if (bus.state_o == S_MEM_RD && waited < wait_rd) begin
          bus.mem_ready = 1'b0;
          waited++;
        end else begin
          bus.mem_ready = 1'b1;
        end
        bus.opcode = (k == 1) ? op : 6'($urandom);
        #1;
        a = sample();
        if (k == idx) at_idx = a;
        if (a.mr && a.iord) mr_rd++;
        if (a.m2r) m2r++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout op=%b got=no_return want=FETCH", op);
    end
  endtask

  initial begin
    vec_t  tbl[9];
    exp_t  a, e;
    int    cyc, mr_rd, m2r;
    logic [5:0] rop;

    tbl[0].op = 6'b000000; tbl[0].lat = 4; tbl[0].idx = 2;
    tbl[0].exp = e0(S_EXEC_R); tbl[0].exp.sa = 1'b1; tbl[0].exp.aop = 2'b10;
    tbl[1].op = 6'b100011; tbl[1].lat = 5; tbl[1].idx = 2;
    tbl[1].exp = e0(S_MEM_ADDR); tbl[1].exp.sa = 1'b1; tbl[1].exp.sb = 2'b10;
    tbl[2].op = 6'b101011; tbl[2].lat = 4; tbl[2].idx = 2;
    tbl[2].exp = e0(S_MEM_ADDR); tbl[2].exp.sa = 1'b1; tbl[2].exp.sb = 2'b10;
    tbl[3].op = 6'b000100; tbl[3].lat = 3; tbl[3].idx = 2;
    tbl[3].exp = e0(S_BRANCH); tbl[3].exp.sa = 1'b1; tbl[3].exp.aop = 2'b01;
    tbl[3].exp.pcwc = 1'b1; tbl[3].exp.psrc = 2'b01;
    tbl[4].op = 6'b000010; tbl[4].lat = 3; tbl[4].idx = 2;
    tbl[4].exp = e0(S_JUMP); tbl[4].exp.pcw = 1'b1; tbl[4].exp.psrc = 2'b10;
    tbl[5].op = 6'b001000; tbl[5].lat = 4; tbl[5].idx = 2;
    tbl[5].exp = e0(S_EXEC_I); tbl[5].exp.sa = 1'b1; tbl[5].exp.sb = 2'b10;
    tbl[6].op = 6'b001100; tbl[6].lat = 4; tbl[6].idx = 2;
    tbl[6].exp = e0(S_EXEC_I); tbl[6].exp.sa = 1'b1; tbl[6].exp.sb = 2'b10;
    tbl[6].exp.aop = 2'b10; tbl[6].exp.sel = 1'b1;
    tbl[7].op = 6'b001101; tbl[7].lat = 4; tbl[7].idx = 2;
    tbl[7].exp = e0(S_EXEC_I); tbl[7].exp.sa = 1'b1; tbl[7].exp.sb = 2'b10;
    tbl[7].exp.aop = 2'b10; tbl[7].exp.sel = 1'b1;
    tbl[8].op = 6'b111111; tbl[8].lat = 2; tbl[8].idx = 1;
    tbl[8].exp = e0(S_DECODE); tbl[8].exp.sb = 2'b11; tbl[8].exp.ill = 1'b1;

    rst = 1'b1;
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;
    #3;
    check("reset_state", sample(), e0(S_FETCH));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      exec_instr(tbl[i].op, 0, tbl[i].idx, cyc, a, mr_rd, m2r);
      check_int($sformatf("latency_op%b", tbl[i].op), cyc, tbl[i].lat);
      check($sformatf("ctrl_op%b", tbl[i].op), a, tbl[i].exp);
    end

    exec_instr(6'b100011, 3, 0, cyc, a, mr_rd, m2r);
    check_int("lw_wait_total", cyc, 8);
    check_int("lw_wait_mem_read_cycles", mr_rd, 4);
    check_int("lw_wait_mem_to_reg", m2r, 1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: rop = 6'b000000; 1: rop = 6'b100011; 2: rop = 6'b101011;
        3: rop = 6'b000100; 4: rop = 6'b000010; 5: rop = 6'b001000;
        6: rop = 6'b001100; 7: rop = 6'b001101;
        default: rop = 6'($urandom);
      endcase
      model_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    while (q.size() > 0) begin
      step_t s;
      s = q.pop_front();
      step(s.rdy, s.op, a);
      check($sformatf("model_st%0d", s.exp.st), a, s.exp);
    end

    step(1'b1, 6'($urandom), a);
    step(1'b0, 6'b101011, a);
    step(1'b0, 6'($urandom), a);
    step(1'b0, 6'($urandom), a);
    e = e0(S_MEM_WR); e.mw = 1'b1; e.iord = 1'b1;
    check("sw_before_rst", a, e);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_mem_wr", sample(), e0(S_FETCH));
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 6'd0, a);
    e = e0(S_FETCH); e.mr = 1'b1; e.sb = 2'b01;
    check("fetch_after_rst", a, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
